// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the button conditioner: I/O window addresses,
// default parameters and small helpers for parameter sanity checks and
// address decode.
package button_conditioner_pkg;

    // Memory-mapped I/O window used by the CPU-side register stage
    localparam logic [15:0] ADDR_LEDS    = 16'hFFF0;
    localparam logic [15:0] ADDR_BOTONES = 16'hFFE0;
    localparam logic [15:0] ADDR_EVENTOS = 16'hFFE1;
    localparam logic [15:0] ADDR_DECODE_MASK = 16'hFFF0;

    // Default configuration
    localparam int DEFAULT_WIDTH           = 16;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
    localparam int DEFAULT_CNT_W           = 16;

    // The counter must be able to hold DEBOUNCE_CYCLES-1 without wrapping,
    // and a single-cycle debounce window makes no sense.
    function automatic bit debounce_cfg_ok(input int cycles, input int cnt_w);
        bit ok;
        ok = 1'b1;
        if (cycles < 2) begin
            ok = 1'b0;
        end
        if (cnt_w < 1 || cnt_w > 30) begin
            ok = 1'b0;
        end else if ((1 << cnt_w) <= cycles) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    // True when addr falls inside the button register window (0xFFEx)
    function automatic logic is_button_window(input logic [15:0] addr);
        return (addr & ADDR_DECODE_MASK) == (ADDR_BOTONES & ADDR_DECODE_MASK);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single-bit debouncer. s_in must already be synchronised to clk.
// The stable level only follows s_in after s_in has disagreed with it for
// DEBOUNCE_CYCLES consecutive clock edges; any agreement restarts the count.
// rise/fall are combinational one-cycle pulses aligned with the edge on
// which the stable level changes, so the parent can register events on
// the same edge as the level.
module debounce_bit
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic s_in,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_stable;
    logic             w_stable_next;

    // Next count / next stable level: count disagreement, accept on the last one
    always_comb begin
        w_cnt_next    = r_cnt;
        w_stable_next = r_stable;
        if (s_in == r_stable) begin
            w_cnt_next = '0;
        end else if (r_cnt == LAST_CNT) begin
            w_stable_next = s_in;
            w_cnt_next    = '0;
        end else begin
            w_cnt_next = r_cnt + 1'b1;
        end
    end

    // State registers; reset discards any partial count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_next;
            r_stable <= w_stable_next;
        end
    end

    assign stable = r_stable;
    assign rise   = w_stable_next & ~r_stable;
    assign fall   = ~w_stable_next & r_stable;

endmodule

// File: rtl/button_conditioner.sv
// Button conditioner top level.
// Per bit: 2-FF synchroniser -> debounce_bit -> stable level (estado).
// Rising edges of the stable level set sticky press events (eventos) which
// the CPU clears by mask with a one-cycle clr_ev strobe; a set on the same
// edge as a clear wins so no press is ever lost. irq is the registered OR
// of the event registers and changes on the same edge as they do.
// Optional feature macro: BUTTON_RELEASE_EVENTS_EN adds eventos_rel, sticky
// release (1->0) events sharing the same clear strobe/mask and folded into irq.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int WIDTH           = DEFAULT_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] botones,
    input  logic             clr_ev,
    input  logic [WIDTH-1:0] clr_mask,
    output logic [WIDTH-1:0] estado,
    output logic [WIDTH-1:0] eventos,
`ifdef BUTTON_RELEASE_EVENTS_EN
    output logic [WIDTH-1:0] eventos_rel,
`endif
    output logic             irq
);

    // Reject configurations where the debounce counter could wrap
    generate
        if (!debounce_cfg_ok(DEBOUNCE_CYCLES, CNT_W)) begin : g_bad_cfg
            $error("button_conditioner: DEBOUNCE_CYCLES must be >=2 and < 2**CNT_W");
        end
    endgenerate

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] r_eventos;
    logic [WIDTH-1:0] w_eventos_next;
    logic             r_irq;
    logic             w_irq_next;
`ifdef BUTTON_RELEASE_EVENTS_EN
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] r_eventos_rel;
    logic [WIDTH-1:0] w_eventos_rel_next;
`else
    logic [WIDTH-1:0] w_fall_unused;
`endif

    // Two-flop synchroniser; nothing downstream ever sees botones directly
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= botones;
            r_sync2 <= r_sync1;
        end
    end

    // One independent debouncer per button
    genvar b;
    generate
        for (b = 0; b < WIDTH; b++) begin : g_bit
            debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_debounce (
                .clk    (clk),
                .reset  (reset),
                .s_in   (r_sync2[b]),
                .stable (w_stable[b]),
                .rise   (w_rise[b]),
`ifdef BUTTON_RELEASE_EVENTS_EN
                .fall   (w_fall[b])
`else
                .fall   (w_fall_unused[b])
`endif
            );
        end
    endgenerate

    assign w_clr = clr_mask & {WIDTH{clr_ev}};

    // Next event state: clear selected bits, then OR in new edges (set wins)
    always_comb begin
        w_eventos_next = (r_eventos & ~w_clr) | w_rise;
`ifdef BUTTON_RELEASE_EVENTS_EN
        w_eventos_rel_next = (r_eventos_rel & ~w_clr) | w_fall;
        w_irq_next         = (|w_eventos_next) | (|w_eventos_rel_next);
`else
        w_irq_next         = |w_eventos_next;
`endif
    end

    // Sticky event registers and interrupt, updated on the same edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_eventos <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_eventos <= w_eventos_next;
            r_irq     <= w_irq_next;
        end
    end

`ifdef BUTTON_RELEASE_EVENTS_EN
    // Sticky release-event register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_eventos_rel <= '0;
        end else begin
            r_eventos_rel <= w_eventos_rel_next;
        end
    end

    assign eventos_rel = r_eventos_rel;
`endif

    assign estado  = w_stable;
    assign eventos = r_eventos;
    assign irq     = r_irq;

endmodule
